// File: rtl/tt_um_arq_rx.sv
// tt_um_arq_rx - stop-and-wait ARQ receiver tile.
//
// Receives 3-byte frames (header, payload, check) from the link. Each frame's
// sync pattern, sequence bit and checksum are validated, and a one-cycle
// ACK/NAK pulse is returned. Accepted in-order payloads are queued in a
// first-word-fall-through FIFO that the consumer drains.
//
// Ports
//   clk      clock
//   rst_n    asynchronous active-low reset
//   ena      powered indicator, unused
//   ui_in    link byte, sampled while rx_valid=1
//   uo_out   FIFO head payload, 0x00 when empty
//   uio_in   [0] rx_valid, [1] rd_en, [7:2] unused
//   uio_out  [3] ack, [4] nak, [5] resp_seq, [6] empty, [7] full, [2:0] 0
//   uio_oe   constant 8'hF8
//
// FSM states
//   state  | meaning
//   S_IDLE | hunting for a header byte (0xAA / 0xAB); other bytes dropped
//   S_HDR  | header latched, waiting for payload byte
//   S_PAY  | payload latched, waiting for check byte (accept edge)

module tt_um_arq_rx #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [7:0] TO_LOAD = 8'(TIMEOUT);
   localparam logic [6:0] SYNC = 7'h55;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_PAY  = 2'd2
   } state_t;

   logic rx_valid;
   logic rd_en;
   assign rx_valid = uio_in[0];
   assign rd_en    = uio_in[1];

   logic unused_ok;
   assign unused_ok = &{1'b0, ena, uio_in[7:2]};

   state_t state_q, state_d;

   logic          seq_q;
   logic [7:0]    pay_q;
   logic          exp_seq_q;
   logic [7:0]    to_cnt_q;
   logic          ack_q, nak_q, resp_seq_q;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   logic empty, full;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   logic hdr_ld, pay_ld, accept, chk_ok, is_dup, take;
   logic push, pop, ack_d, nak_d;
   logic to_expire;

   // to_cnt_q holds the idle cycles still allowed; reaching 1 on an idle
   // cycle means this is the TIMEOUT-th consecutive idle cycle.
   assign to_expire = !rx_valid && (to_cnt_q == 8'd1);

   always_comb begin
      state_d = state_q;
      hdr_ld  = 1'b0;
      pay_ld  = 1'b0;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_valid && (ui_in[7:1] == SYNC)) begin
               hdr_ld  = 1'b1;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            if (rx_valid) begin
               pay_ld  = 1'b1;
               state_d = S_PAY;
            end else if (to_expire) begin
               state_d = S_IDLE;
            end
         end
         S_PAY: begin
            if (rx_valid) begin
               accept  = 1'b1;
               state_d = S_IDLE;
            end else if (to_expire) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Decision uses the registered full flag; a pop in the accept cycle does
   // not free a slot for this frame.
   assign chk_ok = (ui_in == ~({SYNC, seq_q} ^ pay_q));
   assign is_dup = (seq_q != exp_seq_q);
   assign take   = chk_ok && (is_dup || !full);
   assign push   = accept && chk_ok && !is_dup && !full;
   assign ack_d  = accept && take;
   assign nak_d  = accept && !take;
   assign pop    = rd_en && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q      <= 1'b0;
         pay_q      <= 8'h00;
         exp_seq_q  <= 1'b0;
         to_cnt_q   <= 8'h00;
         ack_q      <= 1'b0;
         nak_q      <= 1'b0;
         resp_seq_q <= 1'b0;
      end else begin
         if (hdr_ld) seq_q <= ui_in[0];
         if (pay_ld) pay_q <= ui_in;
         if (push) exp_seq_q <= ~exp_seq_q;
         if (rx_valid) begin
            to_cnt_q <= TO_LOAD;
         end else if ((state_q != S_IDLE) && (to_cnt_q != 8'h00)) begin
            to_cnt_q <= to_cnt_q - 8'd1;
         end
         ack_q      <= ack_d;
         nak_q      <= nak_d;
         resp_seq_q <= accept ? seq_q : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= pay_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   assign uo_out  = empty ? 8'h00 : mem[rd_ptr_q];
   assign uio_out = {full, empty, resp_seq_q, nak_q, ack_q, 3'b000};
   assign uio_oe  = 8'hF8;

endmodule

// File: tb/tb_tt_um_arq_rx.sv
// Directed bench for tt_um_arq_rx with hand-computed expectations.
module tb_tt_um_arq_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] uo_out, uio_out, uio_oe;
   logic [7:0] uio_in;

   int total = 0;
   int bad = 0;

   assign uio_in = {6'b0, rd_en, rx_valid};

   tt_um_arq_rx #(.DEPTH(8), .TIMEOUT(255)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rd_en    = 1'b0;
      rst_n    = 1'b0;
      step();
      rst_n    = 1'b1;
      step();
   endtask

   task automatic send_byte(input logic [7:0] b);
      ui_in    = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   // Leaves outputs in the cycle where the response pulse is visible.
   task automatic send_frame(input logic [7:0] h, input logic [7:0] p, input logic [7:0] c);
      ui_in = h; rx_valid = 1'b1; step();
      ui_in = p; step();
      ui_in = c; step();
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pop1();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   logic [7:0] h, p;
   logic       seen_resp;

   initial begin
      // reset state
      #2;
      chk("rst_uio_out", uio_out, 8'h40);
      chk("rst_uo_out", uo_out, 8'h00);
      chk("uio_oe", uio_oe, 8'hF8);
      do_reset();

      // good frame
      send_frame(8'hAA, 8'h3C, 8'h69);
      chk("good_ack", uio_out[3], 1);
      chk("good_nak", uio_out[4], 0);
      chk("good_rseq", uio_out[5], 0);
      chk("good_uo", uo_out, 8'h3C);
      chk("good_empty", uio_out[6], 0);
      step();
      chk("ack_one_cycle", uio_out, 8'h00);
      pop1();
      chk("pop_uo", uo_out, 8'h00);
      chk("pop_empty", uio_out[6], 1);

      // sequence + duplicate, back-to-back
      do_reset();
      send_frame(8'hAA, 8'h3C, 8'h69);
      chk("seq0_resp", uio_out[5:3], 3'b001);
      send_frame(8'hAB, 8'h5A, 8'h0E);
      chk("seq1_resp", uio_out[5:3], 3'b101);
      send_frame(8'hAB, 8'h5A, 8'h0E);
      chk("dup_resp", uio_out[5:3], 3'b101);
      chk("dup_head", uo_out, 8'h3C);
      pop1();
      chk("dup_second", uo_out, 8'h5A);
      pop1();
      chk("dup_drained", uo_out, 8'h00);
      chk("dup_empty", uio_out[6], 1);

      // bad checksum
      do_reset();
      send_frame(8'hAA, 8'h3C, 8'h68);
      chk("badc_resp", uio_out[5:3], 3'b010);
      chk("badc_empty", uio_out[6], 1);
      send_frame(8'hAA, 8'h3C, 8'h69);
      chk("resend_resp", uio_out[5:3], 3'b001);
      chk("resend_uo", uo_out, 8'h3C);
      send_frame(8'hAB, 8'h00, 8'h55);
      chk("badc1_resp", uio_out[5:3], 3'b110);

      // full FIFO
      do_reset();
      for (int i = 0; i < 8; i++) begin
         h = 8'hAA | 8'(i & 1);
         p = 8'h10 + 8'(i);
         send_frame(h, p, ~(h ^ p));
         chk($sformatf("fill_ack%0d", i), uio_out[5:3], {h[0], 2'b01});
      end
      chk("full_flag", uio_out[7], 1);
      chk("full_head", uo_out, 8'h10);
      send_frame(8'hAA, 8'h18, 8'h4D);
      chk("full_nak", uio_out[5:3], 3'b010);
      chk("full_still", uio_out[7], 1);
      // nak even though a pop happens in the accept cycle
      ui_in = 8'hAA; rx_valid = 1'b1; step();
      ui_in = 8'h18; step();
      ui_in = 8'h4D; rd_en = 1'b1; step();
      rx_valid = 1'b0; rd_en = 1'b0;
      chk("full_pop_nak", uio_out[5:3], 3'b010);
      chk("full_pop_notfull", uio_out[7], 0);
      chk("full_pop_head", uo_out, 8'h11);
      send_frame(8'hAA, 8'h18, 8'h4D);
      chk("full_resend_ack", uio_out[5:3], 3'b001);
      chk("full_again", uio_out[7], 1);
      for (int i = 1; i < 9; i++) begin
         chk($sformatf("drain%0d", i), uo_out, 8'h10 + 8'(i));
         pop1();
      end
      chk("drain_empty", uio_out, 8'h40);
      pop1();
      chk("pop_when_empty", uio_out, 8'h40);

      // junk bytes are ignored
      do_reset();
      send_byte(8'h00);
      send_byte(8'hFF);
      chk("junk_quiet", uio_out, 8'h40);
      send_frame(8'hAA, 8'h3C, 8'h69);
      chk("after_junk_ack", uio_out[5:3], 3'b001);

      // timeout drops partial frame after 255 idle cycles
      do_reset();
      send_byte(8'hAA);
      send_byte(8'h3C);
      seen_resp = 1'b0;
      for (int i = 0; i < 255; i++) begin
         step();
         if (uio_out[4:3] != 2'b00) seen_resp = 1'b1;
      end
      chk("to_no_resp", seen_resp, 0);
      send_byte(8'h69);
      chk("to_dropped", uio_out, 8'h40);
      // 254 idle cycles are tolerated
      send_byte(8'hAA);
      send_byte(8'h3C);
      idle(254);
      send_byte(8'h69);
      chk("to_tolerated", uio_out[5:3], 3'b001);
      chk("to_tol_uo", uo_out, 8'h3C);

      // reset mid-frame
      step();
      send_byte(8'hAB);
      rst_n = 1'b0;
      #1;
      chk("midrst_uio", uio_out, 8'h40);
      chk("midrst_uo", uo_out, 8'h00);
      step();
      rst_n = 1'b1;
      step();
      send_byte(8'h5A);
      send_byte(8'h0E);
      chk("midrst_discard", uio_out, 8'h40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
